// File: rtl/johnson_seq_ctrl.sv
// johnson_seq_ctrl: command-driven sequencer for a WIDTH-stage Johnson
// (twisted-ring) phase register. A command carries a direction, a step count
// and a step period; the block advances the phase one code per period and
// pulses done when the run completes or is aborted.
//
// state  | meaning
// IDLE   | ready for a command, phase held
// RUN    | prescaler counting, phase steps every div+1 cycles
// FINISH | one-cycle done pulse, done_aborted qualifies it
module johnson_seq_ctrl #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8,
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_dir,
  input  logic [CNT_W-1:0] cmd_steps,
  input  logic [DIV_W-1:0] cmd_div,
  input  logic             abort,
  output logic [WIDTH-1:0] phase,
  output logic             step_stb,
  output logic             busy,
  output logic             done,
  output logic             done_aborted
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FINISH = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic             dir_q;
  logic [DIV_W-1:0] div_q;
  logic [DIV_W-1:0] presc;
  logic [CNT_W-1:0] remaining;

  logic accept;
  logic step;
  logic stop_abort;
  logic last_step;

  assign last_step = (remaining == CNT_W'(1));

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode plus the accept/step/abort strobes that drive the datapath.
  always_comb begin
    state_nxt  = state;
    accept     = 1'b0;
    step       = 1'b0;
    stop_abort = 1'b0;
    case (state)
      IDLE: begin
        if (cmd_valid) begin
          accept    = 1'b1;
          state_nxt = (cmd_steps == '0) ? FINISH : RUN;
        end
      end
      RUN: begin
        // Abort wins over a coincident step so the phase holds on that edge.
        if (abort) begin
          stop_abort = 1'b1;
          state_nxt  = FINISH;
        end else if (presc == div_q) begin
          step = 1'b1;
          if (last_step) begin
            state_nxt = FINISH;
          end
        end
      end
      FINISH: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Command latch, prescaler, remaining-step counter, phase register and flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      phase        <= '0;
      step_stb     <= 1'b0;
      done_aborted <= 1'b0;
      presc        <= '0;
      remaining    <= '0;
      dir_q        <= 1'b0;
      div_q        <= '0;
    end else begin
      step_stb <= step;
      if (accept) begin
        dir_q     <= cmd_dir;
        div_q     <= cmd_div;
        remaining <= cmd_steps;
        presc     <= '0;
        if (cmd_steps == '0) begin
          done_aborted <= 1'b0;
        end
      end else if (stop_abort) begin
        done_aborted <= 1'b1;
      end else if (step) begin
        if (dir_q) begin
          phase <= {~phase[0], phase[WIDTH-1:1]};
        end else begin
          phase <= {phase[WIDTH-2:0], ~phase[WIDTH-1]};
        end
        presc     <= '0;
        remaining <= remaining - CNT_W'(1);
        if (last_step) begin
          done_aborted <= 1'b0;
        end
      end else if (state == RUN) begin
        presc <= presc + DIV_W'(1);
      end
    end
  end

  // Decoded status outputs.
  assign cmd_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  assign done      = (state == FINISH);

endmodule

// File: tb/tb_johnson_seq_ctrl.sv
// tb_johnson_seq_ctrl: scoreboard bench. The driver predicts every step and
// done event (edge index and phase) from a position-on-the-ring model and
// queues it; the monitor pops and compares whenever step_stb or done shows up.
module tb_johnson_seq_ctrl;
  localparam int W  = 4;
  localparam int CW = 8;
  localparam int DW = 8;
  localparam int NPOS = 2 * W;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic          cmd_dir = 1'b0;
  logic [CW-1:0] cmd_steps = '0;
  logic [DW-1:0] cmd_div = '0;
  logic          abort = 1'b0;
  logic [W-1:0]  phase;
  logic          step_stb;
  logic          busy;
  logic          done;
  logic          done_aborted;

  johnson_seq_ctrl #(.WIDTH(W), .CNT_W(CW), .DIV_W(DW)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_dir(cmd_dir), .cmd_steps(cmd_steps), .cmd_div(cmd_div), .abort(abort),
    .phase(phase), .step_stb(step_stb), .busy(busy), .done(done),
    .done_aborted(done_aborted)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    logic [W-1:0] ph;
    bit          ab;
  } ev_t;

  ev_t sq[$];
  ev_t dq[$];
  int  checks = 0;
  int  errors = 0;
  int  cyc = 0;
  int  pos = 0;
  int  free_edge = 0;

  // Edge counter: at a negedge, cyc is the index of the most recent rising edge.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Johnson code at ring position i: positions 0..W fill ones from the LSB,
  // positions W..2W-1 then clear them from the LSB.
  function automatic logic [W-1:0] code(input int i);
    int v;
    if (i < W) v = (1 << i) - 1;
    else       v = ((1 << W) - 1) & ~((1 << (i - W)) - 1);
    return v[W-1:0];
  endfunction

  // Monitor: any step or done pulse must match the head of its queue.
  always @(negedge clk) begin
    ev_t e;
    if (!reset) begin
      if (step_stb) begin
        if (sq.size() == 0) chk("unexpected_step", 1, 0);
        else begin
          e = sq.pop_front();
          chk("step_cycle", cyc, e.cyc);
          chk("step_phase", phase, e.ph);
        end
      end
      if (done) begin
        if (dq.size() == 0) chk("unexpected_done", 1, 0);
        else begin
          e = dq.pop_front();
          chk("done_cycle", cyc, e.cyc);
          chk("done_phase", phase, e.ph);
          chk("done_aborted", done_aborted, e.ab);
        end
      end
    end
  end

  // Issue one command from a negedge. abort_k>0 asserts abort for the single
  // edge E0+abort_k. Returns after the handshake (and abort), or after the run
  // has returned to IDLE when wait_done is set.
  task automatic run_cmd(input bit dir, input int steps, input int div,
                         input int abort_k, input bit wait_done);
    int  e0, per, ea, d, edge_k;
    bit  aeff, ab;
    cmd_valid = 1'b1;
    cmd_dir   = dir;
    cmd_steps = CW'(steps);
    cmd_div   = DW'(div);
    e0  = (cyc + 1 > free_edge) ? cyc + 1 : free_edge;
    per = div + 1;
    ea  = e0 + abort_k;
    aeff = (abort_k > 0) && (steps > 0) && (ea <= e0 + steps * per);
    ab   = 1'b0;
    for (int k = 1; k <= steps; k++) begin
      edge_k = e0 + k * per;
      if (aeff && edge_k >= ea) break;
      pos = dir ? (pos + NPOS - 1) % NPOS : (pos + 1) % NPOS;
      sq.push_back('{cyc: edge_k, ph: code(pos), ab: 1'b0});
    end
    if (steps == 0)  d = e0;
    else if (aeff) begin d = ea; ab = 1'b1; end
    else             d = e0 + steps * per;
    dq.push_back('{cyc: d, ph: code(pos), ab: ab});
    free_edge = d + 2;
    while (cyc < e0 - 1) begin
      chk("ready_low_while_busy", cmd_ready, 0);
      @(negedge clk);
    end
    chk("ready_before_accept", cmd_ready, 1);
    chk("busy_before_accept", busy, 0);
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("busy_after_accept", busy, 1);
    if (abort_k > 0) begin
      while (cyc < ea - 1) @(negedge clk);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
    end
    if (wait_done) begin
      while (cyc < free_edge - 1) @(negedge clk);
      chk("ready_after_done", cmd_ready, 1);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int s, dv, ak;
    bit dr;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_phase", phase, 0);
    chk("rst_ready", cmd_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_step_stb", step_stb, 0);
    chk("rst_done_aborted", done_aborted, 0);
    #2 reset = 1'b0;
    @(negedge clk);

    run_cmd(1'b0, 3, 1, -1, 1'b1);   // 0001, 0011, 0111 every 2 cycles
    run_cmd(1'b0, 5, 0, -1, 1'b1);   // back to 0000
    run_cmd(1'b1, 3, 0, -1, 1'b1);   // 1000, 1100, 1110
    run_cmd(1'b0, 3, 0, -1, 1'b1);   // back to 0000
    run_cmd(1'b0, 8, 0, -1, 1'b1);   // full ring, ends 0000
    run_cmd(1'b0, 9, 0, -1, 1'b1);   // ends 0001
    run_cmd(1'b1, 1, 2, -1, 1'b1);   // back to 0000
    run_cmd(1'b0, 10, 3, 12, 1'b1);  // abort on third step edge, holds 0011
    chk("abort_hold_phase", phase, 4'b0011);
    run_cmd(1'b0, 0, 5, -1, 1'b1);   // zero steps: done only
    run_cmd(1'b0, 4, 2, -1, 1'b0);   // next command waits under backpressure
    run_cmd(1'b1, 2, 1, -1, 1'b1);
    run_cmd(1'b1, 255, 0, -1, 1'b1); // maximum step count

    for (int n = 0; n < 40; n++) begin
      dr = 1'($urandom_range(0, 1));
      s  = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 20));
      dv = int'($urandom_range(0, 4));
      ak = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, s * (dv + 1) + 2)) : -1;
      run_cmd(dr, s, dv, ak, 1'($urandom_range(0, 1)));
    end
    while (cyc < free_edge - 1) @(negedge clk);

    // Asynchronous reset in the middle of a run.
    run_cmd(1'b0, 20, 2, -1, 1'b0);
    repeat (7) @(negedge clk);
    chk("busy_mid_run", busy, 1);
    #2 reset = 1'b1;
    #1;
    chk("async_rst_phase", phase, 0);
    chk("async_rst_busy", busy, 0);
    chk("async_rst_ready", cmd_ready, 1);
    chk("async_rst_done", done, 0);
    sq.delete();
    dq.delete();
    pos = 0;
    free_edge = 0;
    @(negedge clk);
    #2 reset = 1'b0;
    @(negedge clk);
    chk("post_rst_done", done, 0);
    run_cmd(1'b1, 2, 0, -1, 1'b1);  // 1000, 1100

    repeat (5) @(negedge clk);
    chk("step_queue_drained", sq.size(), 0);
    chk("done_queue_drained", dq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/johnson_seq_ctrl.md
Name: johnson_seq_ctrl

Overview:
- Sequencer and controller for a WIDTH-stage Johnson (twisted-ring) phase register, e.g. stepper-motor or multiphase-clock drive.
- Accepts a command of direction, step count and step-rate divider over a valid/ready handshake.
- Advances the Johnson phase one state per step period, in the requested direction, then reports completion.
- Sits between a host/register block and the phase outputs.

Parameters:
- WIDTH, 4, Johnson stages; sequence length 2*WIDTH.
- CNT_W, 8, width of step-count field.
- DIV_W, 8, width of step-rate divider field.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  block can accept a command.
- cmd_dir  in  1  0 = forward, 1 = reverse.
- cmd_steps  in  CNT_W  number of steps to take.
- cmd_div  in  DIV_W  step period minus one, in clk cycles.
- abort  in  1  terminate the current run.
- phase  out  WIDTH  Johnson phase register.
- step_stb  out  1  one-cycle pulse after each phase update.
- busy  out  1  command in progress.
- done  out  1  one-cycle completion pulse.
- done_aborted  out  1  qualifies done; 1 = run ended by abort.

Behaviour:
- Reset values:
  - Asserting reset forces state IDLE, phase=0, step_stb=0, done_aborted=0, and clears the prescaler and step counter.
  - Outputs after reset: cmd_ready=1, busy=0, done=0.
- Single clock domain. Everything except reset is synchronous to clk rising edge.
- Forward step: phase <= {phase[WIDTH-2:0], ~phase[WIDTH-1]}. For WIDTH=4 the sequence is 0000,0001,0011,0111,1111,1110,1100,1000, then wraps to 0000.
- Reverse step: phase <= {~phase[0], phase[WIDTH-1:1]}. This is the exact inverse of the forward step.
- Phase is retained between commands. It is never reset except by reset.
- FSM has three states: IDLE, RUN, FINISH.
- Decoded outputs:
  - cmd_ready = (state==IDLE).
  - busy = (state!=IDLE).
  - done = (state==FINISH).
- IDLE:
  - Handshake fires on cmd_valid && cmd_ready at edge E0.
  - On handshake, latch cmd_dir, cmd_steps and cmd_div; clear the prescaler.
  - If cmd_steps==0, go to FINISH with done_aborted=0. Otherwise go to RUN.
  - cmd_valid while busy is ignored; the command is not queued.
- RUN:
  - The prescaler counts 0..div.
  - When prescaler==div at an edge: advance phase, clear the prescaler, decrement remaining, and set step_stb=1 for the following cycle.
  - Step k (1-based) occurs at edge E0 + k*(div+1).
  - On the step edge where remaining==1, go to FINISH with done_aborted=0.
  - div=0 gives one step per cycle.
- abort:
  - Sampled only in RUN. abort=1 at an edge means go to FINISH with done_aborted=1.
  - No step on that edge, even if the prescaler is at div. Phase holds.
  - abort in IDLE or FINISH is ignored.
- FINISH:
  - Lasts one cycle (done=1), then returns to IDLE.
  - done_aborted holds its value until the next FINISH entry.
- Counter widths:
  - remaining is CNT_W bits and cmd_steps is unsigned, so the maximum run is 2^CNT_W-1 steps.
  - The prescaler is DIV_W bits and never wraps past div.
- Reset mid-run: the run is dropped immediately. There is no done pulse, and phase returns to 0.

Test Plan:
- Reset, then forward run: cmd_dir=0, cmd_steps=3, cmd_div=1 accepted at E0 → phase 0001@E2, 0011@E4, 0111@E6. step_stb high in the cycles after E2/E4/E6. done=1 and done_aborted=0 in the cycle E6–E7. cmd_ready=1 after E7.
- Reverse from 0000: cmd_dir=1, steps=3, div=0 → phase 1000, 1100, 1110 on consecutive edges. done follows the third step.
- Wrap: forward, steps=8, div=0 from 0000 → all 8 Johnson codes in order, ending at 0000. Then forward steps=9 ends at 0001.
- Abort: steps=10, div=3. Assert abort on the edge where prescaler==3 after step 2 → no third step, phase stays 0011. One done pulse with done_aborted=1.
- Zero steps and backpressure:
  - steps=0 → done one cycle after accept, phase unchanged.
  - A second cmd_valid held during busy is not accepted until cmd_ready=1, then runs normally.
- Async reset mid-run: assert reset between clock edges during RUN → phase=0, busy=0 and cmd_ready=1 immediately, with no done pulse.
